// File: rtl/alu32_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu32_seq
// Purpose  : Sequencing stage for an external combinational 32-bit add/sub ALU.
//            Accepts one operation over a valid/ready handshake and drives
//            registered operands plus the add/sub select into the ALU. Captures
//            the ALU result and flags one cycle later, then presents them
//            downstream over a second valid/ready handshake. Keeps a 32-bit
//            accumulator for chained operations and a sticky overflow flag.
// Ports    :
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_op                    00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB
//   in_a, in_b               operands (in_a ignored for ACC_* ops)
//   alu_sub_add/alu_a/alu_b  registered drive into the ALU
//   alu_result/alu_carry/
//   alu_zero/alu_overflow    ALU outputs, captured at the end of EXEC
//   out_valid/out_ready      result handshake
//   out_result/out_carry/
//   out_zero/out_overflow    captured result and flags
//   acc                      accumulator (written by every operation)
//   sticky_ovf/clr_sticky    sticky overflow flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module alu32_seq #(
  parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        alu_sub_add,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_carry,
  output logic        out_zero,
  output logic        out_overflow,
  output logic [31:0] acc,
  output logic        sticky_ovf,
  input  logic        clr_sticky
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        sub_q, sub_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic [31:0] acc_q, acc_d;
  logic        sticky_q, sticky_d;

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    sticky_d = clr_sticky ? 1'b0 : sticky_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sub_d   = in_op[0];
          // ACC_* ops take the accumulator as it stands before this edge.
          a_d     = in_op[1] ? acc_q : in_a;
          b_d     = in_b;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        carry_d = alu_carry;
        zero_d  = alu_zero;
        ovf_d   = alu_overflow;
        acc_d   = alu_result;
        // A captured overflow outranks a simultaneous clear.
        if (alu_overflow) begin
          sticky_d = 1'b1;
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sub_q    <= 1'b0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      res_q    <= 32'h0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= ACC_INIT;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  // Handshake outputs depend only on the state register (and reset for
  // in_ready), never on in_valid or out_ready.
  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign out_valid    = (state_q == S_HOLD);

  assign alu_sub_add  = sub_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign out_result   = res_q;
  assign out_carry    = carry_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign acc          = acc_q;
  assign sticky_ovf   = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_alu32_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu32_seq
// Purpose  : Self-checking bench for alu32_seq. Provides a behavioural model
//            of the downstream add/sub ALU, applies a table of operations
//            through a scoreboard queue, then runs hand-written sequences for
//            backpressure, sticky-clear collision and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu32_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        alu_sub_add;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic        out_overflow;
  logic [31:0] acc;
  logic        sticky_ovf;
  logic        clr_sticky;

  alu32_seq #(.ACC_INIT(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_sub_add  (alu_sub_add),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .acc          (acc),
    .sticky_ovf   (sticky_ovf),
    .clr_sticky   (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU model: subtract is a + ~b + 1, carry is the raw carry out.
  logic [31:0] alu_bb;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bb       = alu_sub_add ? ~alu_b : alu_b;
    alu_sum      = {1'b0, alu_a} + {1'b0, alu_bb} + {32'h0, alu_sub_add};
    alu_result   = alu_sum[31:0];
    alu_carry    = alu_sum[32];
    alu_zero     = (alu_sum[31:0] == 32'h0);
    alu_overflow = (alu_a[31] == alu_bb[31]) && (alu_sum[31] != alu_a[31]);
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        v;
    logic [31:0] acc;
    logic        sticky;
  } vec_t;

  vec_t        sb_q[$];
  vec_t        tbl[8];
  logic [31:0] m_acc;
  int          total;
  int          bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one operation through both handshakes with out_ready high.
  task automatic do_op(input vec_t v);
    int   n;
    vec_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_timeout", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    tick();
    in_valid = 1'b0;
    sb_q.push_back(v);
    chk("alu_a", alu_a, v.op[1] ? m_acc : v.a);
    chk("alu_b", alu_b, v.b);
    chk("alu_sub_add", {31'h0, alu_sub_add}, {31'h0, v.op[0]});
    chk("exec_in_ready", {31'h0, in_ready}, 32'h0);
    chk("exec_out_valid", {31'h0, out_valid}, 32'h0);
    m_acc = v.acc;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, 1);
    if (out_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("out_result", out_result, e.res);
      chk("out_carry", {31'h0, out_carry}, {31'h0, e.c});
      chk("out_zero", {31'h0, out_zero}, {31'h0, e.z});
      chk("out_overflow", {31'h0, out_overflow}, {31'h0, e.v});
      chk("acc", acc, e.acc);
      chk("sticky_ovf", {31'h0, sticky_ovf}, {31'h0, e.sticky});
    end
    tick();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    m_acc      = 32'h0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = 2'b00;
    in_a       = 32'h0;
    in_b       = 32'h0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;

    //        op     a              b              res            c     z     v     acc            sticky
    tbl[0] = '{2'b00, 32'd5,         32'd3,         32'd8,         1'b0, 1'b0, 1'b0, 32'd8,         1'b0};
    tbl[1] = '{2'b01, 32'd3,         32'd3,         32'd0,         1'b1, 1'b1, 1'b0, 32'd0,         1'b0};
    tbl[2] = '{2'b00, 32'h7FFF_FFFF, 32'd0,         32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0};
    tbl[3] = '{2'b10, 32'hDEAD_BEEF, 32'd1,         32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1};
    tbl[4] = '{2'b11, 32'h1234_5678, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1};
    tbl[5] = '{2'b00, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b1, 1'b0, 32'd0,         1'b1};
    tbl[6] = '{2'b01, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{2'b10, 32'd0,         32'd2,         32'd1,         1'b1, 1'b0, 1'b0, 32'd1,         1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_acc", acc, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_sticky", {31'h0, sticky_ovf}, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", {31'h0, in_ready}, 32'h1);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i]);
    end

    // Backpressure: ADD 10+20 held in HOLD for 5 cycles with a pending request.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 2'b00;
    in_a      = 32'd10;
    in_b      = 32'd20;
    tick();
    in_a = 32'd1;
    in_b = 32'd1;
    tick();
    chk("bp_first_result", out_result, 32'd30);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_result_stable", out_result, 32'd30);
      chk("bp_acc_stable", acc, 32'd30);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_not_accepted", alu_a, 32'd10);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_ready", {31'h0, in_ready}, 32'h1);
    chk("bp_idle_valid", {31'h0, out_valid}, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("bp_accept_a", alu_a, 32'd1);
    tick();
    chk("bp_next_result", out_result, 32'd2);
    chk("bp_next_acc", acc, 32'd2);
    tick();

    // Sticky clear alone, then collision with a captured overflow.
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_cleared", {31'h0, sticky_ovf}, 32'h0);
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_a     = 32'h7FFF_FFFF;
    in_b     = 32'd1;
    tick();
    in_valid   = 1'b0;
    clr_sticky = 1'b1;
    tick();
    chk("coll_overflow", {31'h0, out_overflow}, 32'h1);
    chk("coll_sticky_set", {31'h0, sticky_ovf}, 32'h1);
    tick();
    clr_sticky = 1'b0;
    chk("coll_sticky_clr", {31'h0, sticky_ovf}, 32'h0);
    m_acc = 32'h8000_0000;

    // Reset during EXEC of ACC_ADD b=7 with acc=10.
    do_op('{2'b00, 32'd4, 32'd6, 32'd10, 1'b0, 1'b0, 1'b0, 32'd10, 1'b0});
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_a     = 32'd0;
    in_b     = 32'd7;
    tick();
    in_valid = 1'b0;
    chk("mid_alu_a", alu_a, 32'd10);
    rst = 1'b1;
    tick();
    chk("mid_acc", acc, 32'h0);
    chk("mid_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_out_result", out_result, 32'h0);
    chk("mid_out_flags", {29'h0, out_carry, out_zero, out_overflow}, 32'h0);
    chk("mid_alu_regs", alu_a | alu_b | {31'h0, alu_sub_add}, 32'h0);
    chk("mid_in_ready", {31'h0, in_ready}, 32'h0);
    rst   = 1'b0;
    m_acc = 32'h0;
    sb_q.delete();
    do_op('{2'b00, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu32_seq.md
# alu32_seq

Sequencing stage that sits directly upstream of the combinational 32-bit add/sub ALU and consumes its outputs. It accepts one operation at a time over a valid/ready handshake and drives registered operands and the add/sub select into the ALU. It captures the ALU result and flags, then presents them downstream over a second valid/ready handshake. It also keeps a 32-bit accumulator for chained operations and a sticky overflow flag.

## Interface
- ACC_INIT, 32'h0000_0000, accumulator value after reset
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept an operation
- in_op  input  2  00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB
- in_a  input  32  operand A, two's complement; ignored for ACC_* ops
- in_b  input  32  operand B, two's complement
- alu_sub_add  output  1  to ALU: 0 add, 1 subtract (registered)
- alu_a  output  32  to ALU operand a (registered)
- alu_b  output  32  to ALU operand b (registered)
- alu_result  input  32  from ALU
- alu_carry, alu_zero, alu_overflow  input  1 each  ALU flags
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_result  output  32  captured result
- out_carry, out_zero, out_overflow  output  1 each  captured flags
- acc  output  32  accumulator
- sticky_ovf  output  1  set by any captured overflow
- clr_sticky  input  1  clears sticky_ovf

## Operation
- FSM has three states.
  - IDLE: in_ready=1. When in_valid=1, load the ALU registers and go to EXEC:
    - alu_sub_add <= in_op[0]
    - alu_a <= in_op[1] ? acc : in_a
    - alu_b <= in_b
  - EXEC: in_ready=0 and out_valid=0. The ALU output settles during this cycle. At the closing edge:
    - out_result/out_carry/out_zero/out_overflow <= alu_* inputs
    - acc <= alu_result for every op, including plain ADD/SUB
    - sticky_ovf <= sticky_ovf | alu_overflow
    - go to HOLD
  - HOLD: out_valid=1. When out_ready=1, go to IDLE. Otherwise stay, and keep all out_* and acc stable.
- in_ready is 0 in EXEC and HOLD. A new request is never accepted in the same cycle as an output handshake.
- alu_* registers hold their last value outside IDLE-accept. The ALU inputs therefore stay stable from EXEC through HOLD.
- The block does no arithmetic of its own. Flags are passed through exactly as the ALU reports them.
- clr_sticky=1 clears sticky_ovf in any state. If it coincides with an EXEC capture where alu_overflow=1, the set wins and sticky_ovf=1.
- Undefined in_op values do not exist: the 2-bit encoding is exhaustive.

## Timing
- Reset values (rst high at an edge):
  - state=IDLE, acc=ACC_INIT
  - all alu_* outputs 0
  - all out_* outputs 0, out_valid=0
  - sticky_ovf=0
  - in_ready=0 while rst=1
- Reset takes effect at any state, including EXEC and HOLD. An in-flight operation is discarded without updating acc.
- Latency:
  - Request accepted at edge N.
  - ALU driven from N.
  - Result captured at edge N+1.
  - out_valid=1 from N+1.
  - The earliest next accept is the edge after the output handshake.
- Throughput: one operation per 3 cycles with out_ready held high.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready.
- An ACC_* op accepted at edge N uses the acc value present before edge N. This includes a value written by the immediately preceding operation.

## Test plan
- Plain ops:
  - ADD, a=5, b=3 -> out_result=8, zero=0, overflow=0, acc=8, out_valid one cycle after accept.
  - SUB, a=3, b=3 -> out_result=0, out_zero=1, acc=0.
- Accumulate overflow:
  - ADD a=32'h7FFF_FFFF, b=0, then ACC_ADD b=1 -> out_result=32'h8000_0000, out_overflow=1, sticky_ovf=1.
  - Then ACC_SUB b=1 -> result 32'h7FFF_FFFF, overflow=1, sticky stays 1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD.
  - out_* and acc stay stable, in_ready=0, and a held in_valid is not accepted.
  - Release out_ready -> IDLE next cycle, then accept.
- Sticky clear collision: clr_sticky=1 in the same EXEC cycle that captures overflow=1 -> sticky_ovf=1.
  - clr_sticky alone on the next cycle -> sticky_ovf=0.
- Reset mid-operation: assert rst during EXEC of ACC_ADD b=7 with acc=10.
  - Next cycle: acc=ACC_INIT, out_valid=0, all out_* and alu_* outputs =0.
  - After rst deasserts, a fresh ADD 1+1 -> out_result=2.
